// File: rtl/bidir_bus_pkg.sv
// Shared types and helpers for the bidirectional bus controller.
//   state_e    : controller FSM states
//   cnt_width  : width of the shared wait/turnaround down-counter
//   DEF_*      : default parameter values
package bidir_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_TURNAROUND = 1;

  // Wide enough to hold max(read_wait, turnaround); never narrower than 1 bit.
  function automatic int cnt_width(input int read_wait, input int turnaround);
    int m;
    m = (read_wait > turnaround) ? read_wait : turnaround;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bidir_bus_cnt.sv
// Loadable down-counter with zero flag.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement; saturates at 0
//   zero       : count == 0
module bidir_bus_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Sequencer in front of a tristate buffer on a half-duplex bus. Accepts single-beat
// read/write requests and inserts turnaround so local and remote drivers never overlap.
//   req_valid/req_write/req_wdata/req_ready : request handshake (req_ready combinational)
//   rsp_valid/rsp_rdata                     : one-cycle read response, data held
//   bus_out/bus_oe                          : to buffer a / g
//   bus_in                                  : pad readback
//   bus_wr_stb/bus_rd_stb                   : strobes to the peer
//   busy                                    : state != IDLE
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int READ_WAIT  = DEF_READ_WAIT,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  input  logic [WIDTH-1:0] bus_in,
  output logic             bus_wr_stb,
  output logic             bus_rd_stb,
  output logic             busy
);

  if (READ_WAIT < 1) begin : g_bad_read_wait
    $error("bidir_bus_ctrl: READ_WAIT must be >= 1");
  end
  if (TURNAROUND < 0) begin : g_bad_turnaround
    $error("bidir_bus_ctrl: TURNAROUND must be >= 0");
  end

  localparam int CW        = cnt_width(READ_WAIT, TURNAROUND);
  localparam int RD_LOAD   = (READ_WAIT > 1) ? READ_WAIT - 1 : 0;
  localparam int TURN_LOAD = (TURNAROUND > 1) ? TURNAROUND - 1 : 0;
  localparam logic [CW-1:0] RD_LOAD_V   = CW'(RD_LOAD);
  localparam logic [CW-1:0] TURN_LOAD_V = CW'(TURN_LOAD);
  localparam bit HAS_TURN = (TURNAROUND > 0);

  state_e state_q, state_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_load_val;
  logic             capture;

  logic             bus_oe_d, bus_wr_stb_d, bus_rd_stb_d, busy_d, rsp_valid_d;
  logic [WIDTH-1:0] bus_out_d, rsp_rdata_d;

  assign req_ready = (state_q == IDLE) & rst_n;

  bidir_bus_cnt #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_write) begin
            state_d = DRIVE;
          end else begin
            state_d      = READ;
            cnt_load     = 1'b1;
            cnt_load_val = RD_LOAD_V;
          end
        end
      end
      DRIVE: begin
        if (HAS_TURN) begin
          state_d      = TURN;
          cnt_load     = 1'b1;
          cnt_load_val = TURN_LOAD_V;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (cnt_zero) begin
          capture = 1'b1;
          if (HAS_TURN) begin
            state_d      = TURN;
            cnt_load     = 1'b1;
            cnt_load_val = TURN_LOAD_V;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      TURN: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    // DRIVE is only entered from an IDLE handshake, so req_wdata is the live payload here.
    bus_oe_d     = (state_d == DRIVE);
    bus_out_d    = bus_oe_d ? req_wdata : '0;
    bus_wr_stb_d = bus_oe_d;
    bus_rd_stb_d = (state_d == READ);
    busy_d       = (state_d != IDLE);
    rsp_valid_d  = capture;
    rsp_rdata_d  = capture ? bus_in : rsp_rdata;
  end

  // Async reset drops bus_oe immediately to release the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bus_oe     <= 1'b0;
      bus_out    <= '0;
      bus_wr_stb <= 1'b0;
      bus_rd_stb <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      bus_oe     <= bus_oe_d;
      bus_out    <= bus_out_d;
      bus_wr_stb <= bus_wr_stb_d;
      bus_rd_stb <= bus_rd_stb_d;
      busy       <= busy_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
module tb_bidir_bus_ctrl;

  localparam int TA = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // dut: WIDTH=8, READ_WAIT=2, TURNAROUND=1
  logic       req_valid, req_write, req_ready, rsp_valid, bus_oe, bus_wr_stb, bus_rd_stb, busy;
  logic [7:0] req_wdata, rsp_rdata, bus_out, bus_in;
  // dut0: WIDTH=8, READ_WAIT=1, TURNAROUND=0
  logic       req_valid0, req_write0, req_ready0, rsp_valid0, bus_oe0, bus_wr_stb0;
  logic       bus_rd_stb0, busy0;
  logic [7:0] req_wdata0, rsp_rdata0, bus_out0, bus_in0;

  bidir_bus_ctrl #(.WIDTH(8), .READ_WAIT(2), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .bus_wr_stb(bus_wr_stb), .bus_rd_stb(bus_rd_stb), .busy(busy)
  );

  bidir_bus_ctrl #(.WIDTH(8), .READ_WAIT(1), .TURNAROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_write(req_write0),
    .req_wdata(req_wdata0), .req_ready(req_ready0), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .bus_out(bus_out0), .bus_oe(bus_oe0), .bus_in(bus_in0),
    .bus_wr_stb(bus_wr_stb0), .bus_rd_stb(bus_rd_stb0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] wq[$];   // expected write payloads (dut)
  logic [7:0] rq[$];   // expected read data (dut)
  logic [7:0] rq0[$];  // expected read data (dut0)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    chk("contention", 32'(bus_oe & bus_rd_stb), 0);
    if (bus_wr_stb) begin
      chk("wr_expected", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) chk("wr_data", 32'(bus_out), 32'(wq.pop_front()));
      chk("wr_oe", 32'(bus_oe), 1);
    end
    if (rsp_valid) begin
      chk("rsp_expected", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) chk("rsp_data", 32'(rsp_rdata), 32'(rq.pop_front()));
    end
    if (rsp_valid0) begin
      chk("rsp0_expected", 32'(rq0.size() > 0), 1);
      if (rq0.size() > 0) chk("rsp0_data", 32'(rsp_rdata0), 32'(rq0.pop_front()));
    end
  end

  // Turnaround gap monitor: idle cycles between the end of one transaction and the next start.
  logic prev_act = 1'b0, seen = 1'b0;
  int   gap = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act <= 1'b0;
      seen     <= 1'b0;
      gap      <= 0;
    end else begin
      if ((bus_oe | bus_rd_stb) && !prev_act && seen) chk("turn_gap", 32'(gap >= TA), 1);
      if (bus_oe | bus_rd_stb) begin
        prev_act <= 1'b1;
        seen     <= 1'b1;
        gap      <= 0;
      end else begin
        prev_act <= 1'b0;
        gap      <= gap + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("ready_timeout", 32'(req_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hFF; bus_in = 8'h00;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_wdata0 = 8'h00; bus_in0 = 8'h00;

    // Reset with a pending request
    tick(); tick();
    chk("rst_oe", 32'(bus_oe), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out", 32'(bus_out), 0);
    chk("rst_strobes", 32'({bus_wr_stb, bus_rd_stb}), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(req_ready), 1);

    // Single write 0xA5
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hA5;
    wq.push_back(8'hA5);
    tick();
    req_valid = 1'b0;
    chk("wr_t1_oe", 32'(bus_oe), 1);
    chk("wr_t1_out", 32'(bus_out), 32'h A5);
    chk("wr_t1_stb", 32'(bus_wr_stb), 1);
    chk("wr_t1_ready", 32'(req_ready), 0);
    tick();
    chk("wr_turn_oe", 32'(bus_oe), 0);
    chk("wr_turn_stb", 32'(bus_wr_stb), 0);
    chk("wr_turn_busy", 32'(busy), 1);
    chk("wr_turn_ready", 32'(req_ready), 0);
    tick();
    chk("wr_ready_back", 32'(req_ready), 1);
    chk("wr_idle_busy", 32'(busy), 0);

    // Single read, peer drives 0x3C
    req_valid = 1'b1; req_write = 1'b0; bus_in = 8'h3C;
    rq.push_back(8'h3C);
    tick();
    req_valid = 1'b0;
    chk("rd_c1_stb", 32'(bus_rd_stb), 1);
    chk("rd_c1_oe", 32'(bus_oe), 0);
    tick();
    chk("rd_c2_stb", 32'(bus_rd_stb), 1);
    chk("rd_c2_rsp", 32'(rsp_valid), 0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_stb_done", 32'(bus_rd_stb), 0);
    chk("rd_turn_ready", 32'(req_ready), 0);
    bus_in = 8'h99;
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 0);
    chk("rd_ready_back", 32'(req_ready), 1);
    tick();
    chk("rd_hold", 32'(rsp_rdata), 32'h3C);

    // Back-to-back with req_valid held: write 0x11, read 0x6E, write 0x22
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h11;
    wq.push_back(8'h11);
    wait_ready(); tick();
    req_write = 1'b0; bus_in = 8'h6E;
    rq.push_back(8'h6E);
    wait_ready(); tick();
    req_write = 1'b1; req_wdata = 8'h22;
    wq.push_back(8'h22);
    wait_ready(); tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("b2b_wq_empty", 32'(wq.size()), 0);
    chk("b2b_rq_empty", 32'(rq.size()), 0);

    // TURNAROUND=0, READ_WAIT=1: write then read
    req_valid0 = 1'b1; req_write0 = 1'b1; req_wdata0 = 8'h5F;
    @(negedge clk);
    chk("t0_ready", 32'(req_ready0), 1);
    tick();
    req_valid0 = 1'b0;
    chk("t0_drive_oe", 32'(bus_oe0), 1);
    chk("t0_drive_out", 32'(bus_out0), 32'h5F);
    tick();
    chk("t0_ready_after_drive", 32'(req_ready0), 1);
    chk("t0_oe_off", 32'(bus_oe0), 0);
    req_valid0 = 1'b1; req_write0 = 1'b0; bus_in0 = 8'h4B;
    rq0.push_back(8'h4B);
    tick();
    req_valid0 = 1'b0;
    chk("t0_rd_stb", 32'(bus_rd_stb0), 1);
    tick();
    chk("t0_rsp_valid", 32'(rsp_valid0), 1);
    chk("t0_rsp_ready", 32'(req_ready0), 1);
    tick();
    chk("t0_rq_empty", 32'(rq0.size()), 0);

    // Async reset during DRIVE
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    chk("rstdrv_oe_before", 32'(bus_oe), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstdrv_oe_async", 32'(bus_oe), 0);
    chk("rstdrv_stb_async", 32'(bus_wr_stb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset during READ: abandoned, no response
    req_valid = 1'b1; req_write = 1'b0; bus_in = 8'h5A;
    tick();
    req_valid = 1'b0;
    chk("rstrd_stb", 32'(bus_rd_stb), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrd_stb_async", 32'(bus_rd_stb), 0);
    chk("rstrd_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstrd_no_rsp", 32'(rsp_valid), 0);
    end
    chk("rstrd_rdata_clr", 32'(rsp_rdata), 0);

    // Fresh read after reset
    req_valid = 1'b1; req_write = 1'b0; bus_in = 8'hC3;
    rq.push_back(8'hC3);
    wait_ready(); tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rq.size() == 0) break;
    end
    chk("final_rsp_drained", 32'(rq.size()), 0);
    chk("final_rdata", 32'(rsp_rdata), 32'hC3);
    chk("final_wq_empty", 32'(wq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
- Sequencer sitting directly upstream of the tristate_buffer on a shared half-duplex data bus.
- Accepts single-beat read/write requests over a valid/ready handshake.
- Drives the buffer's data input (bus_out → a) and enable (bus_oe → g), and samples the pad readback (bus_in) for reads.
- Inserts programmable turnaround so the local driver and the remote peer never drive the bus at the same time.

Parameters:
- WIDTH, 8: data bus width; must match the downstream tristate_buffer WIDTH.
- READ_WAIT, 2: cycles the peer is given to drive read data; legal range ≥1.
- TURNAROUND, 1: bus-idle cycles with bus_oe=0 appended after every transaction; legal range ≥0.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- req_valid  in  1  request present.
- req_write  in  1  1=write, 0=read; qualified by req_valid.
- req_wdata  in  WIDTH  write data; qualified by req_valid & req_write.
- req_ready  out  1  controller can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata valid.
- rsp_rdata  out  WIDTH  captured read data.
- bus_out  out  WIDTH  to tristate_buffer a.
- bus_oe  out  1  to tristate_buffer g.
- bus_in  in  WIDTH  pad readback (bus value).
- bus_wr_stb  out  1  write strobe to peer.
- bus_rd_stb  out  1  read strobe to peer; peer drives the bus while high.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - bus_oe=0 immediately, without waiting for a clock edge; this is required for contention safety.
  - bus_out=0, bus_wr_stb=0, bus_rd_stb=0, rsp_valid=0, rsp_rdata=0, busy=0, counter=0.
  - req_ready=0 while rst_n=0.
- Register outputs: every output except req_ready is registered.
- req_ready:
  - Combinational, equal to (state==IDLE) & rst_n.
  - Handshake is req_valid & req_ready at a rising edge.
  - Requests are never dropped; req_valid may stay high across non-ready cycles, and the payload must stay stable while waiting.
- States: IDLE, DRIVE, READ, TURN.
- IDLE:
  - Handshake with req_write=1 → DRIVE.
  - Handshake with req_write=0 → READ (counter loaded with READ_WAIT-1).
- DRIVE (exactly 1 cycle):
  - bus_oe=1, bus_out=captured req_wdata, bus_wr_stb=1.
  - Next state: TURN if TURNAROUND>0, else IDLE.
- READ (READ_WAIT cycles):
  - bus_oe=0, bus_rd_stb=1, counter decrements.
  - At the edge ending the last READ cycle (counter==0): rsp_rdata<=bus_in and rsp_valid<=1.
  - Next state: TURN if TURNAROUND>0, else IDLE.
- TURN (TURNAROUND cycles):
  - bus_oe=0, both strobes 0, bus_out=0.
  - Counter loaded with TURNAROUND-1 on entry; at counter==0 → IDLE.
- Outside DRIVE: bus_oe=0 and bus_out=0.
- rsp_valid:
  - High for exactly one cycle, the cycle after the last READ cycle; no backpressure.
  - rsp_rdata holds its value until the next read capture.
- Timing, for a handshake at edge T:
  - Write: DRIVE occupies cycle T..T+1.
  - Read: strobe for READ_WAIT cycles, then rsp_valid in the following cycle.
  - Next req_ready: after 1+TURNAROUND cycles for a write, after READ_WAIT+TURNAROUND cycles for a read.
- TURNAROUND=0: back-to-back transactions are allowed. bus_oe may transition 1→0 or 0→1 between consecutive cycles, which is the integrator's choice.
- Counter width: $clog2(max(READ_WAIT,TURNAROUND)+1). It never wraps; the decrement is gated at 0.
- Reset mid-transaction: the transaction is abandoned. No rsp_valid is issued, and bus_oe drops asynchronously.
- Illegal parameters (READ_WAIT<1, TURNAROUND<0): elaboration-time $error.

Decomposition:
- Package bidir_bus_pkg: state enum (IDLE, DRIVE, READ, TURN), a cnt_width function, and default parameter constants.
- Sub-module bidir_bus_cnt: loadable down-counter with a zero flag, instantiated once.
- Top-level integration wraps bidir_bus_ctrl plus tristate_buffer; that wrapper is not part of this block.

Test Plan:
- Reset: hold rst_n=0 while driving req_valid=1 → bus_oe=0, req_ready=0, all outputs 0. Assert rst_n=0 asynchronously during DRIVE → bus_oe falls before the next clk edge.
- Write, WIDTH=8, TURNAROUND=1: req 0xA5 accepted at T → at T+1 bus_oe=1, bus_out=0xA5, bus_wr_stb=1 for one cycle; T+2 TURN with bus_oe=0; req_ready=1 again at T+3.
- Read, READ_WAIT=2: bench drives bus_in=0x3C during the strobe → bus_rd_stb=1 for 2 cycles, bus_oe=0 throughout; rsp_valid pulses once with rsp_rdata=0x3C; rsp_rdata holds afterwards.
- Back-to-back: write 0x11, read, write 0x22 with req_valid held continuously → no cycle has bus_oe=1 and bus_rd_stb=1 together; a gap of ≥TURNAROUND cycles with bus_oe=0 separates each transaction; payload order is preserved.
- TURNAROUND=0, READ_WAIT=1: write then read → req_ready returns the cycle after DRIVE; read response is issued 2 cycles after the handshake.
- Reset during READ: rst_n pulsed low mid-strobe → no rsp_valid is issued; after release, a new read returns the correct bus_in value.
